// File: rtl/pipe_pkg.sv
// Shared types for the 5-stage pipeline hazard sequencer: FSM states,
// scoreboard entry layout and the fixed control words driven to the pipeline buffers.
package pipe_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } pipeState_t;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
    } sbEntry_t;

    typedef struct packed {
        logic pcEn;
        logic ifidEn;
        logic ifidFlush;
        logic idexBubble;
        logic exmemFlush;
    } ctrlWord_t;

    // NOP word: nothing advances and every buffer loads a bubble.
    localparam ctrlWord_t CTRL_NOP    = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    localparam ctrlWord_t CTRL_BRANCH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam ctrlWord_t CTRL_FLUSH  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam ctrlWord_t CTRL_STALL  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam ctrlWord_t CTRL_RUN    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    function automatic logic srcMatch(input sbEntry_t e, input logic [4:0] src);
        return e.v && (src != REG_ZERO) && (e.rd == src);
    endfunction

endpackage

// File: rtl/hz_scoreboard.sv
// Destination-register scoreboard for the EX/MEM/WB stages and the RAW comparators
// that raise hazard for the instruction currently in ID.
module hz_scoreboard
    import pipe_pkg::*;
#(
    parameter bit WB_BYPASS = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue,
    input  logic       idValid,
    input  logic [4:0] idRs,
    input  logic [4:0] idRt,
    input  logic       idUsesRt,
    input  logic       idRegWrite,
    input  logic [4:0] idDest,
    input  logic       memBrTaken,
    output logic       hazard
);

    localparam int DEPTH = WB_BYPASS ? 2 : 3;

    sbEntry_t sb [1:3];

    // NOTE: the entries are reset so a stale rd cannot raise a hazard right after rst;
    // non-blocking assignments make every entry shift from its pre-edge value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb[1] <= '0;
            sb[2] <= '0;
            sb[3] <= '0;
        end else begin
            sb[3] <= sb[2];
            sb[2] <= memBrTaken ? '0 : sb[1];
            sb[1] <= '{v:  issue && idRegWrite && (idDest != REG_ZERO),
                       rd: idDest};
        end
    end

    // NOTE: hazard gets its default before the loop so no path leaves it unassigned.
    always_comb begin
        hazard = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            if (k <= DEPTH && idValid &&
                (srcMatch(sb[k], idRs) || (idUsesRt && srcMatch(sb[k], idRt)))) begin
                hazard = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: RUN/STALL/FLUSH FSM, same-cycle stall and branch-squash controls,
// and saturating stall/flush performance counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter bit WB_BYPASS = 1'b0,
    parameter int FLUSH_CYC = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_reg_write,
    input  logic [4:0]       id_dest,
    input  logic             mem_br_taken,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYC - 1);

    pipeState_t state, nextState;
    logic [1:0] flushLeft, nextFlushLeft;
    logic       hazard;
    logic       issue;
    logic       stallInc;
    logic       flushInc;
    ctrlWord_t  ctrl;

    assign issue    = id_valid && !hazard && (state == RUN) && !mem_br_taken;
    assign stallInc = hazard && !mem_br_taken && (state != FLUSH);
    assign flushInc = mem_br_taken && (state != FLUSH);

    hz_scoreboard #(.WB_BYPASS(WB_BYPASS)) uScoreboard (
        .clk        (clk),
        .rst        (rst),
        .issue      (issue),
        .idValid    (id_valid),
        .idRs       (id_rs),
        .idRt       (id_rt),
        .idUsesRt   (id_uses_rt),
        .idRegWrite (id_reg_write),
        .idDest     (id_dest),
        .memBrTaken (mem_br_taken),
        .hazard     (hazard)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            flushLeft <= '0;
        end else begin
            state     <= nextState;
            flushLeft <= nextFlushLeft;
        end
    end

    always_comb begin
        nextState     = state;
        nextFlushLeft = flushLeft;
        case (state)
            RUN, STALL: begin
                if (mem_br_taken) begin
                    nextState     = FLUSH;
                    nextFlushLeft = FLUSH_LOAD;
                end else begin
                    nextState = hazard ? STALL : RUN;
                end
            end
            FLUSH: begin
                // A second taken branch here belongs to an already squashed instruction.
                if (flushLeft == '0) nextState = RUN;
                else                 nextFlushLeft = flushLeft - 2'd1;
            end
            default: nextState = RUN;
        endcase
    end

    always_comb begin
        ctrl = CTRL_RUN;
        if (rst)                 ctrl = CTRL_NOP;
        else if (mem_br_taken)   ctrl = CTRL_BRANCH;
        else if (state == FLUSH) ctrl = CTRL_FLUSH;
        else if (hazard)         ctrl = CTRL_STALL;
    end

    assign pc_en       = ctrl.pcEn;
    assign ifid_en     = ctrl.ifidEn;
    assign ifid_flush  = ctrl.ifidFlush;
    assign idex_bubble = ctrl.idexBubble;
    assign exmem_flush = ctrl.exmemFlush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stallInc && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flushInc && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: two configurations share stimulus; a reference model of in-flight
// producers queues expected controls/counters, and a negedge monitor compares them.
module tb_pipe_hazard_ctrl;

    localparam int CW0 = 16;
    localparam int CW1 = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic idValid = 1'b0, idUsesRt = 1'b0, idRegWrite = 1'b0, brTaken = 1'b0;
    logic [4:0] idRs = '0, idRt = '0, idDest = '0;

    logic pcEn0, ifidEn0, ifidFlush0, idexBubble0, exmemFlush0;
    logic pcEn1, ifidEn1, ifidFlush1, idexBubble1, exmemFlush1;
    logic [CW0-1:0] stallCnt0, flushCnt0;
    logic [CW1-1:0] stallCnt1, flushCnt1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.WB_BYPASS(1'b0), .FLUSH_CYC(2), .CNT_W(CW0)) dut0 (
        .clk(clk), .rst(rst), .id_valid(idValid), .id_rs(idRs), .id_rt(idRt),
        .id_uses_rt(idUsesRt), .id_reg_write(idRegWrite), .id_dest(idDest),
        .mem_br_taken(brTaken), .pc_en(pcEn0), .ifid_en(ifidEn0), .ifid_flush(ifidFlush0),
        .idex_bubble(idexBubble0), .exmem_flush(exmemFlush0),
        .stall_cnt(stallCnt0), .flush_cnt(flushCnt0)
    );

    pipe_hazard_ctrl #(.WB_BYPASS(1'b1), .FLUSH_CYC(3), .CNT_W(CW1)) dut1 (
        .clk(clk), .rst(rst), .id_valid(idValid), .id_rs(idRs), .id_rt(idRt),
        .id_uses_rt(idUsesRt), .id_reg_write(idRegWrite), .id_dest(idDest),
        .mem_br_taken(brTaken), .pc_en(pcEn1), .ifid_en(ifidEn1), .ifid_flush(ifidFlush1),
        .idex_bubble(idexBubble1), .exmem_flush(exmemFlush1),
        .stall_cnt(stallCnt1), .flush_cnt(flushCnt1)
    );

    typedef struct packed {
        logic [1:0][4:0]  ctrl;
        logic [1:0][15:0] sc;
        logic [1:0][15:0] fc;
    } exp_t;

    exp_t expQ[$];

    // Reference model: producers are tracked by age (1 = in EX, 2 = MEM, 3 = WB).
    int mWindow[2]   = '{3, 2};
    int mFlushCyc[2] = '{2, 3};
    int mCntMax[2]   = '{65535, 15};
    int mMode[2];       // 0 running, 1 stalled, 2 flushing
    int mFlushLeft[2];
    int mStall[2];
    int mFlush[2];
    int pRd[2][3];
    int pAge[2][3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic modelReset(input int i);
        mMode[i] = 0;
        mFlushLeft[i] = 0;
        mStall[i] = 0;
        mFlush[i] = 0;
        for (int k = 0; k < 3; k++) begin
            pRd[i][k] = 0;
            pAge[i][k] = 0;
        end
    endtask

    task automatic modelStep(input logic r, input logic v, input logic [4:0] rs,
                             input logic [4:0] rt, input logic ur, input logic rw,
                             input logic [4:0] d, input logic br);
        exp_t e;
        bit hz, iss;
        e = '0;
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                modelReset(i);
                e.ctrl[i] = 5'b00111;
            end else begin
                hz = 0;
                if (v) begin
                    for (int k = 0; k < 3; k++) begin
                        if (pAge[i][k] != 0 && pAge[i][k] <= mWindow[i] &&
                            ((rs != 0 && pRd[i][k] == int'(rs)) ||
                             (ur && rt != 0 && pRd[i][k] == int'(rt)))) hz = 1;
                    end
                end
                e.sc[i] = 16'(mStall[i]);
                e.fc[i] = 16'(mFlush[i]);
                if (br)                e.ctrl[i] = 5'b11111;
                else if (mMode[i] == 2) e.ctrl[i] = 5'b11110;
                else if (hz)           e.ctrl[i] = 5'b00010;
                else                   e.ctrl[i] = 5'b11000;

                iss = v && !hz && mMode[i] == 0 && !br;
                for (int k = 0; k < 3; k++) begin
                    if (pAge[i][k] != 0) begin
                        if (br && pAge[i][k] == 1) pAge[i][k] = 0;
                        else pAge[i][k] = (pAge[i][k] >= 3) ? 0 : pAge[i][k] + 1;
                    end
                end
                if (iss && rw && d != 0) begin
                    for (int k = 0; k < 3; k++) begin
                        if (pAge[i][k] == 0 && iss) begin
                            pAge[i][k] = 1;
                            pRd[i][k] = int'(d);
                            iss = 0;
                        end
                    end
                end

                if (hz && !br && mMode[i] != 2 && mStall[i] < mCntMax[i]) mStall[i]++;
                if (br && mMode[i] != 2 && mFlush[i] < mCntMax[i]) mFlush[i]++;

                if (mMode[i] != 2 && br) begin
                    mMode[i] = 2;
                    mFlushLeft[i] = mFlushCyc[i];
                end else if (mMode[i] == 2) begin
                    mFlushLeft[i]--;
                    if (mFlushLeft[i] == 0) mMode[i] = 0;
                end else begin
                    mMode[i] = hz ? 1 : 0;
                end
            end
        end
        expQ.push_back(e);
    endtask

    task automatic step(input logic r, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic ur, input logic rw, input logic [4:0] d, input logic br);
        @(posedge clk);
        #1;
        rst = r; idValid = v; idRs = rs; idRt = rt;
        idUsesRt = ur; idRegWrite = rw; idDest = d; brTaken = br;
        modelStep(r, v, rs, rt, ur, rw, d, br);
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic doReset();
        step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                check("ctrl0", 32'({pcEn0, ifidEn0, ifidFlush0, idexBubble0, exmemFlush0}),
                      32'(e.ctrl[0]));
                check("ctrl1", 32'({pcEn1, ifidEn1, ifidFlush1, idexBubble1, exmemFlush1}),
                      32'(e.ctrl[1]));
                check("stall_cnt0", 32'(stallCnt0), 32'(e.sc[0]));
                check("flush_cnt0", 32'(flushCnt0), 32'(e.fc[0]));
                check("stall_cnt1", 32'(stallCnt1), 32'(e.sc[1]));
                check("flush_cnt1", 32'(flushCnt1), 32'(e.fc[1]));
            end
        end
    end

    initial begin : driver
        // add $3,$1,$2 then sub $4,$3,$5 held in ID
        doReset();
        step(0, 1, 5'd1, 5'd2, 1, 1, 5'd3, 0);
        repeat (4) step(0, 1, 5'd3, 5'd5, 1, 1, 5'd4, 0);
        idle(2);
        #2;
        check("raw_stall_cnt_nobypass", 32'(stallCnt0), 32'd3);
        check("raw_stall_cnt_bypass", 32'(stallCnt1), 32'd2);

        // $0 producer and consumer never stall
        doReset();
        step(0, 1, 5'd1, 5'd2, 1, 1, 5'd0, 0);
        repeat (3) step(0, 1, 5'd0, 5'd0, 1, 1, 5'd6, 0);
        idle(1);
        #2;
        check("zero_reg_stall_cnt", 32'(stallCnt0), 32'd0);

        // taken branch with a coincident hazard
        doReset();
        step(0, 1, 5'd1, 5'd2, 1, 1, 5'd3, 0);
        step(0, 1, 5'd3, 5'd5, 1, 1, 5'd4, 1);
        step(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 1);
        idle(4);
        #2;
        check("branch_flush_cnt", 32'(flushCnt0), 32'd1);
        check("branch_stall_cnt", 32'(stallCnt0), 32'd0);

        // lw $7 then sw reading rt=$7, with and without id_uses_rt
        doReset();
        step(0, 1, 5'd1, 5'd0, 0, 1, 5'd7, 0);
        repeat (4) step(0, 1, 5'd2, 5'd7, 1, 0, 5'd0, 0);
        idle(1);
        #2;
        check("rt_used_stall_cnt", 32'(stallCnt0), 32'd3);
        doReset();
        step(0, 1, 5'd1, 5'd0, 0, 1, 5'd7, 0);
        repeat (2) step(0, 1, 5'd2, 5'd7, 0, 0, 5'd0, 0);
        idle(1);
        #2;
        check("rt_unused_stall_cnt", 32'(stallCnt0), 32'd0);

        // reset mid-STALL, then mid-FLUSH
        doReset();
        step(0, 1, 5'd1, 5'd2, 1, 1, 5'd3, 0);
        repeat (2) step(0, 1, 5'd3, 5'd5, 1, 1, 5'd4, 0);
        step(1, 1, 5'd3, 5'd5, 1, 1, 5'd4, 0);
        #2;
        check("rst_stall_cnt", 32'(stallCnt0), 32'd0);
        step(0, 1, 5'd3, 5'd5, 1, 1, 5'd4, 0);
        #2;
        check("post_rst_issue_pc_en", 32'(pcEn0), 32'd1);
        step(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 1);
        step(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0);
        step(1, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0);
        #2;
        check("rst_flush_cnt", 32'(flushCnt0), 32'd0);
        step(0, 1, 5'd3, 5'd4, 1, 1, 5'd5, 0);
        #2;
        check("post_rst_flush_pc_en", 32'(pcEn0), 32'd1);

        // randomized traffic over a small register set to provoke hazards and saturation
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 399) == 0),
                 ($urandom_range(0, 9) < 8),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                 5'($urandom_range(0, 7)),
                 ($urandom_range(0, 11) == 0));
        end

        idle(2);
        repeat (2) @(posedge clk);
        #2;
        check("queue_drained", 32'(expQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
